// File: rtl/alu_op_sequencer.sv
// Command sequencer for an external 18-bit combinational ALU: regfile read, ALU drive, result capture/writeback.
// Optional ALU_SEQ_FLAGS_EN adds registered rsp_zero/rsp_par flags alongside rsp_data.
module alu_op_sequencer #(
  parameter int DATA_W  = 18,
  parameter int REG_CNT = 8,
  parameter int ADDR_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_src_a,
  input  logic [ADDR_W-1:0] cmd_src_b,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic              cmd_wb,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
`ifdef ALU_SEQ_FLAGS_EN
  output logic              rsp_zero,
  output logic              rsp_par,
`endif
  output logic [ADDR_W-1:0] rsp_dst
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   rf_q [REG_CNT];
  logic [DATA_W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [1:0]          alu_op_q, alu_op_d;
  logic [ADDR_W-1:0]   dst_q, dst_d, rsp_dst_q, rsp_dst_d;
  logic                wb_q, wb_d, rsp_vld_q, rsp_vld_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rf_we;
  logic [ADDR_W-1:0]   rf_waddr;
  logic [DATA_W-1:0]   rf_wdata;

  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    dst_d      = dst_q;
    wb_d       = wb_q;
    rsp_vld_d  = rsp_vld_q;
    rsp_data_d = rsp_data_q;
    rsp_dst_d  = rsp_dst_q;
    cmd_ready  = 1'b0;
    rf_we      = 1'b0;
    rf_waddr   = ld_addr;
    rf_wdata   = ld_data;
    case (state_q)
      IDLE: begin
        // Host loads win over commands, so a same-cycle command is stalled one cycle.
        cmd_ready = !ld_valid;
        if (ld_valid) begin
          rf_we = 1'b1;
        end else if (cmd_valid) begin
          alu_a_d  = rf_q[cmd_src_a];
          alu_b_d  = rf_q[cmd_src_b];
          alu_op_d = cmd_op;
          dst_d    = cmd_dst;
          wb_d     = cmd_wb;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d = alu_result;
        rsp_dst_d  = dst_q;
        rsp_vld_d  = 1'b1;
        rf_we      = wb_q;
        rf_waddr   = dst_q;
        rf_wdata   = alu_result;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_vld_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      dst_q      <= '0;
      wb_q       <= 1'b0;
      rsp_vld_q  <= 1'b0;
      rsp_data_q <= '0;
      rsp_dst_q  <= '0;
      for (int i = 0; i < REG_CNT; i++) rf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      dst_q      <= dst_d;
      wb_q       <= wb_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
      rsp_dst_q  <= rsp_dst_d;
      if (rf_we) rf_q[rf_waddr] <= rf_wdata;
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic zero_q, par_q;

  // Flags are captured on the same edge as rsp_data and held with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      par_q  <= 1'b0;
    end else if (state_q == EXEC) begin
      zero_q <= (alu_result == '0);
      par_q  <= ^alu_result;
    end
  end

  assign rsp_zero = zero_q;
  assign rsp_par  = par_q;
`endif

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = rsp_vld_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_dst   = rsp_dst_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed vector table, hand-built hazard/reset sequences, then random traffic
// checked against a plain-arithmetic register-file model. External ALU is modelled here.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_valid;
  logic [2:0]  ld_addr;
  logic [17:0] ld_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_src_a, cmd_src_b, cmd_dst;
  logic        cmd_wb;
  logic [17:0] alu_a, alu_b, alu_result;
  logic [1:0]  alu_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [17:0] rsp_data;
  logic [2:0]  rsp_dst;
`ifdef ALU_SEQ_FLAGS_EN
  logic        rsp_zero, rsp_par;
`endif

  alu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst), .cmd_wb(cmd_wb),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
`ifdef ALU_SEQ_FLAGS_EN
    .rsp_zero(rsp_zero), .rsp_par(rsp_par),
`endif
    .rsp_dst(rsp_dst)
  );

  initial forever #5 clk = ~clk;

  // External combinational ALU.
  always_comb begin
    case (alu_op)
      2'd0:    alu_result = alu_a + alu_b;
      2'd1:    alu_result = alu_a & alu_b;
      2'd2:    alu_result = alu_a | alu_b;
      default: alu_result = alu_a ^ alu_b;
    endcase
  end

  int          passed = 0;
  int          total  = 0;
  logic [17:0] rf_m [8];

  function automatic logic [17:0] ref_alu(input logic [1:0] op, input logic [17:0] a, input logic [17:0] b);
    int unsigned s;
    case (op)
      2'd0: begin
        s = (int'(a) + int'(b)) % 262144;
        return s[17:0];
      end
      2'd1:    return a & b;
      2'd2:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic do_load(input logic [2:0] a, input logic [17:0] d);
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_valid = 1'b0;
    rf_m[a] = d;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [2:0] sa, input logic [2:0] sb,
                         input logic [2:0] dst, input logic wb, input int hold, input logic [17:0] exp);
    int n = 0;
    @(negedge clk);
    cmd_op = op; cmd_src_a = sa; cmd_src_b = sb; cmd_dst = dst; cmd_wb = wb; cmd_valid = 1'b1;
    #1;
    while (!cmd_ready && n < 10) begin
      @(negedge clk); #1; n++;
    end
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("exec_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("alu_a", 32'(alu_a), 32'(rf_m[sa]));
    chk("alu_b", 32'(alu_b), 32'(rf_m[sb]));
    chk("alu_op", 32'(alu_op), 32'(op));
    @(posedge clk); #1;
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_data", 32'(rsp_data), 32'(exp));
    chk("rsp_dst", 32'(rsp_dst), 32'(dst));
`ifdef ALU_SEQ_FLAGS_EN
    chk("rsp_zero", 32'(rsp_zero), 32'(exp == 18'd0));
    chk("rsp_par", 32'(rsp_par), 32'(^exp));
`endif
    for (int i = 0; i < hold; i++) begin
      // Traffic offered while stalled must be refused or ignored.
      cmd_valid = 1'b1; ld_valid = 1'b1; ld_addr = dst; ld_data = ~exp; rsp_ready = 1'b0;
      #1;
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      @(posedge clk); #1;
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_data", 32'(rsp_data), 32'(exp));
    end
    cmd_valid = 1'b0; ld_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_drop", 32'(rsp_valid), 32'd0);
    if (wb) rf_m[dst] = exp;
  endtask

  typedef struct {
    logic        ld_en;
    logic [17:0] va, vb;
    logic [1:0]  op;
    logic [2:0]  sa, sb, dst;
    logic        wb;
    int          hold;
    logic [17:0] exp;
  } vec_t;

  vec_t vt [7];

  initial begin
    vt[0] = '{1'b1, 18'h3FFFF, 18'h00001, 2'd0, 3'd1, 3'd2, 3'd3, 1'b1, 0, 18'h00000};
    vt[1] = '{1'b1, 18'h2AAAA, 18'h15555, 2'd3, 3'd1, 3'd2, 3'd4, 1'b1, 5, 18'h3FFFF};
    vt[2] = '{1'b0, 18'h0,     18'h0,     2'd1, 3'd4, 3'd1, 3'd5, 1'b0, 0, 18'h2AAAA};
    vt[3] = '{1'b0, 18'h0,     18'h0,     2'd2, 3'd5, 3'd5, 3'd6, 1'b0, 0, 18'h00000};
    vt[4] = '{1'b0, 18'h0,     18'h0,     2'd1, 3'd4, 3'd1, 3'd5, 1'b1, 1, 18'h2AAAA};
    vt[5] = '{1'b0, 18'h0,     18'h0,     2'd0, 3'd5, 3'd5, 3'd5, 1'b1, 0, 18'h15554};
    vt[6] = '{1'b0, 18'h0,     18'h0,     2'd2, 3'd5, 3'd3, 3'd7, 1'b0, 2, 18'h15554};

    rst_n = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_src_a = '0; cmd_src_b = '0; cmd_dst = '0; cmd_wb = 1'b0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) rf_m[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    run_cmd(2'd2, 3'd1, 3'd6, 3'd0, 1'b0, 0, 18'h0);

    for (int i = 0; i < 7; i++) begin
      if (vt[i].ld_en) begin
        do_load(vt[i].sa, vt[i].va);
        do_load(vt[i].sb, vt[i].vb);
      end
      run_cmd(vt[i].op, vt[i].sa, vt[i].sb, vt[i].dst, vt[i].wb, vt[i].hold, vt[i].exp);
    end

    // Load and command offered together: load wins, command follows with the new value.
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = 3'd7; ld_data = 18'h12345;
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_src_a = 3'd7; cmd_src_b = 3'd7; cmd_dst = 3'd0; cmd_wb = 1'b0;
    #1;
    chk("ld_blocks_cmd", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    ld_valid = 1'b0;
    rf_m[7] = 18'h12345;
    #1;
    chk("cmd_after_ld_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("cmd_after_ld_alu_a", 32'(alu_a), 32'h12345);
    @(posedge clk); #1;
    chk("cmd_after_ld_data", 32'(rsp_data), 32'h2468A);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;

    // Reset while in EXEC aborts the command and its writeback.
    do_load(3'd2, 18'h00005);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_src_a = 3'd2; cmd_src_b = 3'd2; cmd_dst = 3'd3; cmd_wb = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("pre_rst_alu_a", 32'(alu_a), 32'h5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_alu_a", 32'(alu_a), 32'd0);
    chk("mid_rst_alu_op", 32'(alu_op), 32'd0);
    chk("mid_rst_rsp_dst", 32'(rsp_dst), 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) rf_m[i] = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    run_cmd(2'd2, 3'd3, 3'd2, 3'd1, 1'b0, 0, 18'h0);

    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_load(3'($urandom_range(0, 7)), 18'($urandom));
      end else begin
        logic [1:0] op;
        logic [2:0] sa, sb, dst;
        op  = 2'($urandom_range(0, 3));
        sa  = 3'($urandom_range(0, 7));
        sb  = 3'($urandom_range(0, 7));
        dst = 3'($urandom_range(0, 7));
        run_cmd(op, sa, sb, dst, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                ref_alu(op, rf_m[sa], rf_m[sb]));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
